// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: synchronises the raw PS/2 pins, frames 11-bit
// packets, checks parity/stop, and turns the byte stream into scan codes
// tagged with break (0xF0) and extended (0xE0) prefix flags.
module ps2_scancode_rx #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic [7:0] scan_code,
    output logic       is_break,
    output logic       is_ext,
    output logic       code_valid,
    output logic       frame_err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    localparam logic [15:0] TIMEOUT_VAL = 16'(TIMEOUT_CYCLES);

    logic        clk_meta, clk_sync, clk_prev;
    logic        dat_meta, dat_sync;
    logic        fall;
    logic        frame_good;

    state_t      state, state_next;
    logic [2:0]  bit_cnt, bit_cnt_next;
    logic [7:0]  shift_reg, shift_next;
    logic        parity_bit, parity_next;
    logic [15:0] timeout_cnt, timeout_next;
    logic        brk_pend, brk_next;
    logic        ext_pend, ext_next;
    logic [7:0]  code_next;
    logic        is_break_next, is_ext_next;
    logic        code_valid_next, frame_err_next;

    // Bring the asynchronous PS/2 pins into the CLOCK_50 domain; idle bus is high
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            clk_meta <= 1'b1;
            clk_sync <= 1'b1;
            clk_prev <= 1'b1;
            dat_meta <= 1'b1;
            dat_sync <= 1'b1;
        end else begin
            clk_meta <= PS2_CLK;
            clk_sync <= clk_meta;
            clk_prev <= clk_sync;
            dat_meta <= PS2_DAT;
            dat_sync <= dat_meta;
        end
    end

    assign fall       = clk_prev & ~clk_sync;
    assign frame_good = dat_sync & (^{shift_reg, parity_bit});

    // Hold the frame state, pending prefix flags and registered outputs
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            bit_cnt     <= 3'd0;
            shift_reg   <= 8'h00;
            parity_bit  <= 1'b0;
            timeout_cnt <= 16'd0;
            brk_pend    <= 1'b0;
            ext_pend    <= 1'b0;
            scan_code   <= 8'h00;
            is_break    <= 1'b0;
            is_ext      <= 1'b0;
            code_valid  <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            state       <= state_next;
            bit_cnt     <= bit_cnt_next;
            shift_reg   <= shift_next;
            parity_bit  <= parity_next;
            timeout_cnt <= timeout_next;
            brk_pend    <= brk_next;
            ext_pend    <= ext_next;
            scan_code   <= code_next;
            is_break    <= is_break_next;
            is_ext      <= is_ext_next;
            code_valid  <= code_valid_next;
            frame_err   <= frame_err_next;
        end
    end

    // Frame sequencing on each PS/2 clock fall, timeout recovery and byte decoding
    always_comb begin
        state_next      = state;
        bit_cnt_next    = bit_cnt;
        shift_next      = shift_reg;
        parity_next     = parity_bit;
        brk_next        = brk_pend;
        ext_next        = ext_pend;
        code_next       = scan_code;
        is_break_next   = is_break;
        is_ext_next     = is_ext;
        code_valid_next = 1'b0;
        frame_err_next  = 1'b0;

        if (state == ST_IDLE || fall) begin
            timeout_next = 16'd0;
        end else begin
            timeout_next = timeout_cnt + 16'd1;
        end

        if (state != ST_IDLE && timeout_cnt == TIMEOUT_VAL) begin
            state_next     = ST_IDLE;
            timeout_next   = 16'd0;
            frame_err_next = 1'b1;
            brk_next       = 1'b0;
            ext_next       = 1'b0;
        end else if (fall) begin
            case (state)
                ST_IDLE: begin
                    if (!dat_sync) begin
                        state_next   = ST_DATA;
                        bit_cnt_next = 3'd0;
                    end
                end
                ST_DATA: begin
                    shift_next   = {dat_sync, shift_reg[7:1]};
                    bit_cnt_next = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_next = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    parity_next = dat_sync;
                    state_next  = ST_STOP;
                end
                ST_STOP: begin
                    state_next = ST_IDLE;
                    if (!frame_good) begin
                        frame_err_next = 1'b1;
                        brk_next       = 1'b0;
                        ext_next       = 1'b0;
                    end else if (shift_reg == 8'hF0) begin
                        brk_next = 1'b1;
                    end else if (shift_reg == 8'hE0) begin
                        ext_next = 1'b1;
                    end else begin
                        code_next       = shift_reg;
                        is_break_next   = brk_pend;
                        is_ext_next     = ext_pend;
                        code_valid_next = 1'b1;
                        brk_next        = 1'b0;
                        ext_next        = 1'b0;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Self-checking bench for ps2_scancode_rx: directed scenarios followed by
// randomized frames compared against a byte-level prefix model.
module tb_ps2_scancode_rx;

    localparam int TO = 400;

    logic       clk;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_dat;
    logic [7:0] scan_code;
    logic       is_break;
    logic       is_ext;
    logic       code_valid;
    logic       frame_err;

    int total = 0;
    int bad   = 0;

    int cv_cnt  = 0;
    int fe_cnt  = 0;
    int cv_wide = 0;
    int fe_wide = 0;
    logic cv_prev = 1'b0;
    logic fe_prev = 1'b0;

    ps2_scancode_rx #(.TIMEOUT_CYCLES(TO)) dut (
        .CLOCK_50   (clk),
        .reset      (reset),
        .PS2_CLK    (ps2_clk),
        .PS2_DAT    (ps2_dat),
        .scan_code  (scan_code),
        .is_break   (is_break),
        .is_ext     (is_ext),
        .code_valid (code_valid),
        .frame_err  (frame_err)
    );

    // Free-running 50 MHz system clock
    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // Count output pulses and flag any pulse that lasts more than one cycle
    always @(negedge clk) begin
        if (code_valid) begin
            cv_cnt++;
            if (cv_prev) cv_wide++;
        end
        if (frame_err) begin
            fe_cnt++;
            if (fe_prev) fe_wide++;
        end
        cv_prev = code_valid;
        fe_prev = frame_err;
    end

    // Drive one PS/2 frame: start, 8 data bits LSB-first, parity, stop
    task automatic send_frame(input logic [7:0] data, input bit bad_par, input bit bad_stop, input int half);
        logic [10:0] bits;
        logic par;
        par = ~^data;
        if (bad_par) par = ~par;
        bits = {~bad_stop, par, data, 1'b0};
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            ps2_dat = bits[i];
            repeat (half) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (half) @(negedge clk);
            ps2_clk = 1'b1;
        end
        @(negedge clk);
        ps2_dat = 1'b1;
    endtask

    // Drive a start bit plus the first nbits data bits, leaving PS2_CLK high
    task automatic send_partial(input logic [7:0] data, input int nbits, input int half);
        logic [8:0] bits;
        bits = {data, 1'b0};
        for (int i = 0; i <= nbits; i++) begin
            @(negedge clk);
            ps2_dat = bits[i];
            repeat (half) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (half) @(negedge clk);
            ps2_clk = 1'b1;
        end
    endtask

    task automatic test_reset;
        reset   = 1'b1;
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        repeat (4) @(negedge clk);
        total++;
        if ({scan_code, is_break, is_ext, code_valid, frame_err} !== 12'h000) begin
            bad++;
            $display("[TB] FAIL reset_outputs: got %h want 000", {scan_code, is_break, is_ext, code_valid, frame_err});
        end
        reset = 1'b0;
        repeat (10) @(negedge clk);
        total++;
        if (cv_cnt !== 0 || fe_cnt !== 0) begin
            bad++;
            $display("[TB] FAIL reset_quiet: cv=%0d fe=%0d want 0 0", cv_cnt, fe_cnt);
        end
    endtask

    task automatic test_valid;
        int cv0, fe0, w0;
        cv0 = cv_cnt; fe0 = fe_cnt; w0 = cv_wide;
        send_frame(8'h1C, 0, 0, 150);
        total++;
        if (scan_code !== 8'h1C) begin
            bad++; $display("[TB] FAIL valid_code: got %h want 1c", scan_code);
        end
        total++;
        if (cv_cnt - cv0 !== 1 || cv_wide !== w0) begin
            bad++; $display("[TB] FAIL valid_pulse: pulses=%0d wide=%0d want 1 0", cv_cnt - cv0, cv_wide - w0);
        end
        total++;
        if (is_break !== 1'b0 || is_ext !== 1'b0) begin
            bad++; $display("[TB] FAIL valid_flags: brk=%b ext=%b want 0 0", is_break, is_ext);
        end
        total++;
        if (fe_cnt !== fe0) begin
            bad++; $display("[TB] FAIL valid_noerr: errs=%0d want 0", fe_cnt - fe0);
        end
    endtask

    task automatic test_break;
        int cv0;
        cv0 = cv_cnt;
        send_frame(8'hF0, 0, 0, 40);
        total++;
        if (cv_cnt !== cv0) begin
            bad++; $display("[TB] FAIL break_prefix_silent: pulses=%0d want 0", cv_cnt - cv0);
        end
        send_frame(8'h1C, 0, 0, 40);
        total++;
        if (cv_cnt - cv0 !== 1 || scan_code !== 8'h1C || is_break !== 1'b1) begin
            bad++; $display("[TB] FAIL break_code: pulses=%0d code=%h brk=%b want 1 1c 1", cv_cnt - cv0, scan_code, is_break);
        end
        send_frame(8'h1C, 0, 0, 40);
        total++;
        if (is_break !== 1'b0) begin
            bad++; $display("[TB] FAIL break_cleared: brk=%b want 0", is_break);
        end
    endtask

    task automatic test_ext_break;
        int cv0;
        cv0 = cv_cnt;
        send_frame(8'hE0, 0, 0, 35);
        send_frame(8'hF0, 0, 0, 35);
        send_frame(8'h75, 0, 0, 35);
        total++;
        if (cv_cnt - cv0 !== 1 || scan_code !== 8'h75 || is_ext !== 1'b1 || is_break !== 1'b1) begin
            bad++;
            $display("[TB] FAIL ext_break: pulses=%0d code=%h ext=%b brk=%b want 1 75 1 1", cv_cnt - cv0, scan_code, is_ext, is_break);
        end
    endtask

    task automatic test_bad_frames;
        int cv0, fe0;
        send_frame(8'h29, 0, 0, 30);
        for (int k = 0; k < 2; k++) begin
            cv0 = cv_cnt; fe0 = fe_cnt;
            send_frame(8'h1C, (k == 0), (k == 1), 30);
            total++;
            if (fe_cnt - fe0 !== 1 || cv_cnt !== cv0 || scan_code !== 8'h29) begin
                bad++;
                $display("[TB] FAIL bad_frame_%0d: errs=%0d pulses=%0d code=%h want 1 0 29", k, fe_cnt - fe0, cv_cnt - cv0, scan_code);
            end
        end
        total++;
        if (fe_wide !== 0) begin
            bad++; $display("[TB] FAIL err_width: wide=%0d want 0", fe_wide);
        end
    endtask

    task automatic test_timeout;
        int fe0, n, half;
        bit seen;
        half = 25;
        fe0  = fe_cnt;
        seen = 1'b0;
        n    = 0;
        send_partial(8'h05, 3, half);
        for (int i = 1; i <= 2 * TO; i++) begin
            @(negedge clk);
            if (!seen && fe_cnt != fe0) begin
                seen = 1'b1;
                n    = i;
            end
        end
        total++;
        if (!seen || n < TO + 2 - half || n > TO + 6 - half) begin
            bad++; $display("[TB] FAIL timeout_latency: seen=%b at=%0d want %0d..%0d", seen, n, TO + 2 - half, TO + 6 - half);
        end
        total++;
        if (fe_cnt - fe0 !== 1) begin
            bad++; $display("[TB] FAIL timeout_single: errs=%0d want 1", fe_cnt - fe0);
        end
        send_frame(8'h29, 0, 0, 30);
        total++;
        if (scan_code !== 8'h29) begin
            bad++; $display("[TB] FAIL timeout_recover: code=%h want 29", scan_code);
        end
    endtask

    task automatic test_reset_midframe;
        send_frame(8'hF0, 0, 0, 30);
        send_partial(8'h1C, 5, 30);
        @(negedge clk);
        reset = 1'b1;
        #1;
        total++;
        if ({scan_code, is_break, is_ext, code_valid, frame_err} !== 12'h000) begin
            bad++; $display("[TB] FAIL midreset_outputs: got %h want 000", {scan_code, is_break, is_ext, code_valid, frame_err});
        end
        ps2_dat = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        send_frame(8'h1C, 0, 0, 30);
        total++;
        if (scan_code !== 8'h1C || is_break !== 1'b0) begin
            bad++; $display("[TB] FAIL midreset_recover: code=%h brk=%b want 1c 0", scan_code, is_break);
        end
    endtask

    task automatic test_back_to_back;
        int cv0;
        cv0 = cv_cnt;
        send_frame(8'h16, 0, 0, 20);
        send_frame(8'h1E, 0, 0, 20);
        send_frame(8'h26, 0, 0, 20);
        total++;
        if (cv_cnt - cv0 !== 3 || scan_code !== 8'h26) begin
            bad++; $display("[TB] FAIL back_to_back: pulses=%0d code=%h want 3 26", cv_cnt - cv0, scan_code);
        end
    endtask

    task automatic test_random;
        logic [7:0] m_code, b;
        logic m_brk, m_ext, m_pbrk, m_pext;
        int exp_cv, exp_fe, cv0, fe0, r;
        bit bp, bs;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        m_code = 8'h00; m_brk = 0; m_ext = 0; m_pbrk = 0; m_pext = 0;
        for (int f = 0; f < 16; f++) begin
            r = $urandom_range(0, 5);
            b = (r == 0) ? 8'hF0 : (r == 1) ? 8'hE0 : 8'($urandom_range(0, 255));
            bp = ($urandom_range(0, 7) == 0);
            bs = ($urandom_range(0, 7) == 0);
            exp_cv = 0; exp_fe = 0;
            if (bp || bs) begin
                exp_fe = 1; m_pbrk = 0; m_pext = 0;
            end else if (b == 8'hF0) begin
                m_pbrk = 1;
            end else if (b == 8'hE0) begin
                m_pext = 1;
            end else begin
                exp_cv = 1; m_code = b; m_brk = m_pbrk; m_ext = m_pext; m_pbrk = 0; m_pext = 0;
            end
            cv0 = cv_cnt; fe0 = fe_cnt;
            send_frame(b, bp, bs, $urandom_range(20, 60));
            total++;
            if (cv_cnt - cv0 !== exp_cv || fe_cnt - fe0 !== exp_fe) begin
                bad++;
                $display("[TB] FAIL rand_pulses[%0d] byte=%h: cv=%0d fe=%0d want %0d %0d", f, b, cv_cnt - cv0, fe_cnt - fe0, exp_cv, exp_fe);
            end
            total++;
            if (scan_code !== m_code || is_break !== m_brk || is_ext !== m_ext) begin
                bad++;
                $display("[TB] FAIL rand_state[%0d] byte=%h: got %h/%b/%b want %h/%b/%b", f, b, scan_code, is_break, is_ext, m_code, m_brk, m_ext);
            end
        end
        total++;
        if (cv_wide !== 0 || fe_wide !== 0) begin
            bad++; $display("[TB] FAIL pulse_width: cv_wide=%0d fe_wide=%0d want 0 0", cv_wide, fe_wide);
        end
    endtask

    // Run every scenario in order, then report
    initial begin
        test_reset();
        test_valid();
        test_break();
        test_ext_break();
        test_bad_frames();
        test_timeout();
        test_reset_midframe();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
